mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Multi-cycle multiply/divide unit for the MIPS core; executes MULT, MULTU, DIV and DIVU, which the single-cycle ALU does not implement.
- Sits beside the ALU in the execute stage and owns the architectural HI/LO result pair.
- The core issues operands through a valid/ready request port and collects HI/LO through a valid/ready response port, stalling while the unit is busy.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width; the iteration count equals DATA_WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request; high only in IDLE.
- op  in  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU.
- A  in  DATA_WIDTH  rs operand (multiplicand / dividend).
- B  in  DATA_WIDTH  rt operand (multiplier / divisor).
- out_valid  out  1  HI/LO hold a completed result.
- out_ready  in  1  core consumes the result.
- hi  out  DATA_WIDTH  MULT: upper product; DIV: remainder.
- lo  out  DATA_WIDTH  MULT: lower product; DIV: quotient.
- busy  out  1  high in CALC or DONE.

Behaviour:
- Reset (asynchronous, resetn=0):
  - state goes to IDLE; hi=0, lo=0, out_valid=0, in_ready=1, busy=0.
  - Internal registers are cleared.
  - Reset asserted during CALC or DONE aborts the operation; no result is produced.
- States and transitions:
  - IDLE: accept on an edge with in_valid & in_ready, then go to CALC.
  - CALC: runs DATA_WIDTH cycles, then goes to DONE.
  - DONE: on an edge with out_valid & out_ready, go to IDLE.
- Accept edge:
  - Latch op.
  - Signed ops: latch |A| and |B| and record result signs. Quotient sign = A[31]^B[31]; remainder sign = A[31]; product sign = A[31]^B[31].
  - Unsigned ops: latch A and B unchanged.
  - Clear the iteration counter.
- CALC:
  - One radix-2 step per cycle: shift-add for multiply, restoring subtract for divide.
  - Uses a 2*DATA_WIDTH accumulator; the counter increments each cycle.
  - On the final step, the sign-corrected result is written to hi/lo and out_valid is set.
- Latency:
  - out_valid rises exactly DATA_WIDTH+1 edges after the accept edge, for every op and operand value; there is no early termination.
- hi/lo behaviour:
  - Change only on the completion edge.
  - Hold their value in IDLE, so the core can read HI/LO at any time after completion.
- DONE:
  - Holds out_valid=1 and stable hi/lo until out_ready.
  - out_valid clears on the handshake edge.
  - in_ready rises the cycle after the handshake; a request is never accepted in the same cycle as the response handshake.
- Requests while busy:
  - in_valid while busy is ignored; the core must hold in_valid until in_ready.
  - op, A and B are sampled only on the accept edge.
- Arithmetic results:
  - Multiply: full 64-bit product, two's complement for MULT.
  - Divide: truncates toward zero; remainder sign follows the dividend.
- Divide by zero (DIV or DIVU with B=0): lo=all ones, hi=A unchanged, normal latency.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0.
- Unspecified: out_ready while out_valid=0 has no effect.

Decomposition:
- Shared package holds:
  - op encodings MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU;
  - state encodings S_IDLE, S_CALC, S_DONE;
  - DATA_WIDTH default.
- One natural sub-module: mdu_step, the combinational single-iteration datapath.
  - Inputs: accumulator, operand, mode.
  - Output: next accumulator.
  - The parent keeps all state, counter and sign-fixup logic.

Test Plan:
- MULT A=0xFFFFFFFD (-3), B=5 -> after 33 edges hi=0xFFFFFFFF, lo=0xFFFFFFF1, out_valid=1.
- MULTU A=B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV A=0xFFFFFFF9 (-7), B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU A=7, B=0 -> lo=0xFFFFFFFF, hi=7.
- DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0; same 33-edge latency.
- Back-pressure, busy requests and reset:
  - Hold out_ready=0 for 10 cycles after completion -> hi/lo and out_valid remain stable.
  - Pulse in_valid while busy -> it is ignored.
  - Assert resetn=0 at cycle 15 of CALC -> outputs return to their reset values immediately.
  - The next MULT 6*7 -> lo=42, hi=0.

Source files
------------

// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package mdu_iter_pkg;

  localparam int unsigned MDU_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on a 2W accumulator.
module mdu_step #(
  parameter int unsigned W = 32
) (
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   operand,
  input  logic           div_mode,
  output logic [2*W-1:0] acc_next
);

  logic [W:0] sum;
  logic [W:0] rem_sh;
  logic [W:0] diff;

  // Multiply: {partial product, remaining multiplier bits}, shifted right each step.
  // Divide:   {partial remainder, dividend/quotient bits}, shifted left each step.
  always_comb begin
    sum    = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? operand : {W{1'b0}})};
    rem_sh = {acc[2*W-1:W], acc[W-1]};
    diff   = rem_sh - {1'b0, operand};
    if (!div_mode) begin
      acc_next = {sum, acc[W-1:1]};
    end else if (!diff[W]) begin
      acc_next = {diff[W-1:0], acc[W-2:0], 1'b1};
    end else begin
      acc_next = {rem_sh[W-1:0], acc[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO pair; fixed DATA_WIDTH+1 cycle latency.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MDU_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  busy
);

  localparam int unsigned CW = $clog2(DATA_WIDTH) + 1;

  state_e                  state, state_next;
  mdu_op_e                 op_r;
  logic [2*DATA_WIDTH-1:0] acc, step_acc, prod_fix;
  logic [DATA_WIDTH-1:0]   operand, a_abs, b_abs, quot, rem, res_hi, res_lo;
  logic [CW-1:0]           count;
  logic                    neg_q, neg_r, div_zero;
  logic                    accept, last, in_div, in_signed, is_div;

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;
  // Steps occupy counts 0..W-1; count W is the sign-fixup/writeback cycle.
  assign last      = (state == S_CALC) && (count == CW'(DATA_WIDTH));
  assign in_div    = op[1];
  assign in_signed = !op[0];
  assign is_div    = (op_r == MDU_DIV) || (op_r == MDU_DIVU);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_CALC;
      S_CALC:  if (last) state_next = S_DONE;
      S_DONE:  if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    a_abs = (in_signed && A[DATA_WIDTH-1]) ? -A : A;
    b_abs = (in_signed && B[DATA_WIDTH-1]) ? -B : B;
  end

  mdu_step #(.W(DATA_WIDTH)) u_step (
    .acc      (acc),
    .operand  (operand),
    .div_mode (is_div),
    .acc_next (step_acc)
  );

  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    quot     = acc[DATA_WIDTH-1:0];
    rem      = acc[2*DATA_WIDTH-1:DATA_WIDTH];
    if (is_div) begin
      res_lo = div_zero ? '1 : (neg_q ? -quot : quot);
      res_hi = neg_r ? -rem : rem;
    end else begin
      res_lo = prod_fix[DATA_WIDTH-1:0];
      res_hi = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_r     <= MDU_MULT;
      acc      <= '0;
      operand  <= '0;
      count    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else if (accept) begin
      op_r     <= mdu_op_e'(op);
      acc      <= {{DATA_WIDTH{1'b0}}, (in_div ? a_abs : b_abs)};
      operand  <= in_div ? b_abs : a_abs;
      neg_q    <= in_signed && (A[DATA_WIDTH-1] ^ B[DATA_WIDTH-1]);
      neg_r    <= in_signed && A[DATA_WIDTH-1];
      div_zero <= (B == '0);
      count    <= '0;
    end else if (state == S_CALC) begin
      if (last) begin
        hi <= res_hi;
        lo <= res_lo;
      end else begin
        acc   <= step_acc;
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed vector bench for mdu_iter: arithmetic table plus back-pressure, busy and reset sequences.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = 2'b00;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] hi, lo;
  logic        busy;

  int passed = 0;
  int total  = 0;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  mdu_iter #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int t;
    @(negedge clk);
    op = o; A = a; B = b; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(input int start, output int n);
    n = start;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("hs_out_valid", 64'(out_valid), 64'd0);
    chk("hs_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    int n;
    vecs[0] = '{"mult_neg3x5",   2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1] = '{"multu_max",     2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{"div_neg7_2",    2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{"divu_by0",      2'b11, 32'd7,        32'd0,        32'd7,        32'hFFFFFFFF};
    vecs[4] = '{"div_overflow",  2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
    vecs[5] = '{"mult_m1xm1",    2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1};
    vecs[6] = '{"div_7_neg2",    2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[7] = '{"div_neg7_by0",  2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[8] = '{"mult_min_min",  2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0};
    vecs[9] = '{"divu_big",      2'b11, 32'hFFFFFFFF, 32'd16,       32'd15,       32'h0FFFFFFF};

    #12;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(0, n);
      chk({vecs[i].name, "_latency"}, 64'(n), 64'd33);
      chk({vecs[i].name, "_hi"}, 64'(hi), 64'(vecs[i].hi));
      chk({vecs[i].name, "_lo"}, 64'(lo), 64'(vecs[i].lo));
      handshake();
      repeat (2) @(negedge clk);
      chk({vecs[i].name, "_hold"}, {hi, lo}, {vecs[i].hi, vecs[i].lo});
    end

    // Busy pulse then back-pressure: DIVU 100/7 -> q=14, r=2.
    issue(2'b11, 32'd100, 32'd7);
    for (int i = 0; i < 5; i++) @(posedge clk);
    #1;
    op = 2'b00; A = 32'd1; B = 32'd1; in_valid = 1'b1;
    chk("busy_in_ready", 64'(in_ready), 64'd0);
    chk("busy_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 3; i++) @(posedge clk);
    #1 in_valid = 1'b0;
    wait_done(8, n);
    chk("busy_latency", 64'(n), 64'd33);
    chk("busy_hi", 64'(hi), 64'd2);
    chk("busy_lo", 64'(lo), 64'd14);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_hilo", {hi, lo}, {32'd2, 32'd14});
    end
    handshake();
    chk("bp_no_reaccept", 64'(busy), 64'd0);

    // Reset during CALC aborts; outputs return to reset values immediately.
    issue(2'b00, 32'h12345678, 32'd9);
    for (int i = 0; i < 15; i++) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_result", 64'(out_valid), 64'd0);

    issue(2'b00, 32'd6, 32'd7);
    wait_done(0, n);
    chk("mult6x7_latency", 64'(n), 64'd33);
    chk("mult6x7_hi", 64'(hi), 64'd0);
    chk("mult6x7_lo", 64'(lo), 64'd42);
    handshake();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1);
  end

endmodule
